// File: rtl/ex_stage_mc_if.sv
// ID/EX -> EX/MEM bus of the multi-cycle execute stage: forwarding inputs,
// instruction sideband, stall/busy back-pressure and registered EX/MEM fields.
interface ex_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int OPC_W  = 4
);
  logic              flush;
  logic              id_ex_valid;
  logic [OPC_W-1:0]  id_ex_opcode;
  logic [2:0]        id_ex_cmd;
  logic [1:0]        frwd_op1_sel;
  logic [1:0]        frwd_op2_sel;
  logic [1:0]        frwd_store_sel;
  logic [DATA_W-1:0] frwd_res_ex;
  logic [DATA_W-1:0] frwd_res_mem;
  logic [DATA_W-1:0] frwd_res_wb;
  logic [DATA_W-1:0] rs_1;
  logic [DATA_W-1:0] rs_2;
  logic [DATA_W-1:0] id_ex_store_data;
  logic [RA_W-1:0]   id_ex_op_dest;
  logic              id_ex_mem_write_en;
  logic              id_ex_wb_mux;
  logic              id_ex_wb_en;

  logic              stall;
  logic              busy;
  logic              ex_valid;
  logic [OPC_W-1:0]  opcode_ex_mem;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_zero;
  logic              ex_ovf;
  logic [RA_W-1:0]   ex_op_dest;
  logic              ex_mem_write_en;
  logic              ex_wb_mux;
  logic              ex_wb_en;

  modport master (
    output flush, id_ex_valid, id_ex_opcode, id_ex_cmd,
           frwd_op1_sel, frwd_op2_sel, frwd_store_sel,
           frwd_res_ex, frwd_res_mem, frwd_res_wb,
           rs_1, rs_2, id_ex_store_data, id_ex_op_dest,
           id_ex_mem_write_en, id_ex_wb_mux, id_ex_wb_en,
    input  stall, busy, ex_valid, opcode_ex_mem, alu_res, ex_store_data,
           ex_zero, ex_ovf, ex_op_dest, ex_mem_write_en, ex_wb_mux, ex_wb_en
  );

  modport slave (
    input  flush, id_ex_valid, id_ex_opcode, id_ex_cmd,
           frwd_op1_sel, frwd_op2_sel, frwd_store_sel,
           frwd_res_ex, frwd_res_mem, frwd_res_wb,
           rs_1, rs_2, id_ex_store_data, id_ex_op_dest,
           id_ex_mem_write_en, id_ex_wb_mux, id_ex_wb_en,
    output stall, busy, ex_valid, opcode_ex_mem, alu_res, ex_store_data,
           ex_zero, ex_ovf, ex_op_dest, ex_mem_write_en, ex_wb_mux, ex_wb_en
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: operand forwarding, single-cycle ALU ops,
// DATA_W-iteration shift-add multiply, registered EX/MEM outputs, stall and flush.
module ex_stage_mc #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int OPC_W  = 4
) (
  input logic         clk,
  input logic         rst,
  ex_stage_mc_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0, CMD_SUB = 3'd1, CMD_AND = 3'd2, CMD_OR  = 3'd3,
    CMD_XOR = 3'd4, CMD_SHL = 3'd5, CMD_SHR = 3'd6, CMD_MUL = 3'd7
  } cmd_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DATA_W-1:0] mst_q, mst_d;
  logic [OPC_W-1:0]  mopc_q, mopc_d;
  logic [RA_W-1:0]   mdest_q, mdest_d;
  logic              mmwe_q, mmwe_d, mwbm_q, mwbm_d, mwbe_q, mwbe_d;

  logic              vld_q, vld_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [DATA_W-1:0] res_q, res_d, st_q, st_d;
  logic              zero_q, zero_d, ovf_q, ovf_d;
  logic [RA_W-1:0]   dest_q, dest_d;
  logic              mwe_q, mwe_d, wbm_q, wbm_d, wbe_q, wbe_d;

  logic [DATA_W-1:0] op1, op2, st_fw, alu, acc_sum;
  logic              alu_ovf;
  logic              stall_c;

  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel,
                                            input logic [DATA_W-1:0] ex,
                                            input logic [DATA_W-1:0] mem,
                                            input logic [DATA_W-1:0] wb,
                                            input logic [DATA_W-1:0] rf);
    case (sel)
      2'b10:   fwd = ex;
      2'b11:   fwd = mem;
      2'b01:   fwd = wb;
      default: fwd = rf;
    endcase
  endfunction

  assign op1   = fwd(bus.frwd_op1_sel, bus.frwd_res_ex, bus.frwd_res_mem, bus.frwd_res_wb, bus.rs_1);
  assign op2   = fwd(bus.frwd_op2_sel, bus.frwd_res_ex, bus.frwd_res_mem, bus.frwd_res_wb, bus.rs_2);
  assign st_fw = fwd(bus.frwd_store_sel, bus.frwd_res_ex, bus.frwd_res_mem, bus.frwd_res_wb,
                     bus.id_ex_store_data);

  always_comb begin
    alu     = '0;
    alu_ovf = 1'b0;
    case (cmd_e'(bus.id_ex_cmd))
      CMD_ADD: begin
        alu     = op1 + op2;
        alu_ovf = (op1[MSB] == op2[MSB]) && (alu[MSB] != op1[MSB]);
      end
      CMD_SUB: begin
        alu     = op1 - op2;
        alu_ovf = (op1[MSB] != op2[MSB]) && (alu[MSB] != op1[MSB]);
      end
      CMD_AND: alu = op1 & op2;
      CMD_OR:  alu = op1 | op2;
      CMD_XOR: alu = op1 ^ op2;
      CMD_SHL: alu = op1 << op2[SH_W-1:0];
      CMD_SHR: alu = op1 >> op2[SH_W-1:0];
      default: alu = '0;
    endcase
  end

  // One multiplier bit per cycle: add the shifted multiplicand when its bit is set.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mst_d    = mst_q;
    mopc_d   = mopc_q;
    mdest_d  = mdest_q;
    mmwe_d   = mmwe_q;
    mwbm_d   = mwbm_q;
    mwbe_d   = mwbe_q;
    vld_d    = 1'b0;
    opc_d    = '0;
    res_d    = '0;
    st_d     = '0;
    zero_d   = 1'b0;
    ovf_d    = 1'b0;
    dest_d   = '0;
    mwe_d    = 1'b0;
    wbm_d    = 1'b0;
    wbe_d    = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.id_ex_valid) begin
            if (bus.id_ex_cmd == CMD_MUL) begin
              state_d  = BUSY;
              cnt_d    = '0;
              mcand_d  = op1;
              mplier_d = op2;
              acc_d    = '0;
              mst_d    = st_fw;
              mopc_d   = bus.id_ex_opcode;
              mdest_d  = bus.id_ex_op_dest;
              mmwe_d   = bus.id_ex_mem_write_en;
              mwbm_d   = bus.id_ex_wb_mux;
              mwbe_d   = bus.id_ex_wb_en;
            end else begin
              vld_d  = 1'b1;
              opc_d  = bus.id_ex_opcode;
              res_d  = alu;
              st_d   = st_fw;
              zero_d = (alu == '0);
              ovf_d  = alu_ovf;
              dest_d = bus.id_ex_op_dest;
              mwe_d  = bus.id_ex_mem_write_en;
              wbm_d  = bus.id_ex_wb_mux;
              wbe_d  = bus.id_ex_wb_en;
            end
          end
        end
        BUSY: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            vld_d   = 1'b1;
            opc_d   = mopc_q;
            res_d   = acc_sum;
            st_d    = mst_q;
            zero_d  = (acc_sum == '0);
            dest_d  = mdest_q;
            mwe_d   = mmwe_q;
            wbm_d   = mwbm_q;
            wbe_d   = mwbe_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    stall_c = !rst && !bus.flush &&
              (((state_q == IDLE) && bus.id_ex_valid && (bus.id_ex_cmd == CMD_MUL)) ||
               ((state_q == BUSY) && (cnt_q != CNT_LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mst_q    <= '0;
      mopc_q   <= '0;
      mdest_q  <= '0;
      mmwe_q   <= 1'b0;
      mwbm_q   <= 1'b0;
      mwbe_q   <= 1'b0;
      vld_q    <= 1'b0;
      opc_q    <= '0;
      res_q    <= '0;
      st_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dest_q   <= '0;
      mwe_q    <= 1'b0;
      wbm_q    <= 1'b0;
      wbe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mst_q    <= mst_d;
      mopc_q   <= mopc_d;
      mdest_q  <= mdest_d;
      mmwe_q   <= mmwe_d;
      mwbm_q   <= mwbm_d;
      mwbe_q   <= mwbe_d;
      vld_q    <= vld_d;
      opc_q    <= opc_d;
      res_q    <= res_d;
      st_q     <= st_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dest_q   <= dest_d;
      mwe_q    <= mwe_d;
      wbm_q    <= wbm_d;
      wbe_q    <= wbe_d;
    end
  end

  assign bus.stall           = stall_c;
  assign bus.busy            = (state_q == BUSY);
  assign bus.ex_valid        = vld_q;
  assign bus.opcode_ex_mem   = opc_q;
  assign bus.alu_res         = res_q;
  assign bus.ex_store_data   = st_q;
  assign bus.ex_zero         = zero_q;
  assign bus.ex_ovf          = ovf_q;
  assign bus.ex_op_dest      = dest_q;
  assign bus.ex_mem_write_en = mwe_q;
  assign bus.ex_wb_mux       = wbm_q;
  assign bus.ex_wb_en        = wbe_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: directed corner cases plus random stream
// checked against an arithmetic reference model.
module tb_ex_stage_mc;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_mc_if #(.DATA_W(DW), .RA_W(RW), .OPC_W(OW)) bus ();
  ex_stage_mc #(.DATA_W(DW), .RA_W(RW), .OPC_W(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] st;
    logic        zero;
    logic        ovf;
    logic [3:0]  opc;
    logic [2:0]  dest;
    logic        mwe, wbm, wbe;
  } exp_t;

  typedef struct {
    logic        valid, flush;
    logic [2:0]  cmd;
    logic [3:0]  opc;
    logic [1:0]  s1, s2, ss;
    logic [15:0] ex, mem, wb, r1, r2, sd;
    logic [2:0]  dest;
    logic        mwe, wbm, wbe;
  } ins_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] rf, input ins_t i);
    case (s)
      2'b10:   return i.ex;
      2'b11:   return i.mem;
      2'b01:   return i.wb;
      default: return rf;
    endcase
  endfunction

  function automatic exp_t model(input ins_t i);
    exp_t e;
    logic [15:0] a, b;
    int sa, sb_, sr;
    longint unsigned p;
    e = '0;
    a = pick(i.s1, i.r1, i);
    b = pick(i.s2, i.r2, i);
    sa = $signed(a);
    sb_ = $signed(b);
    case (i.cmd)
      3'd0: begin sr = sa + sb_; e.res = 16'(sr); e.ovf = (sr > 32767) || (sr < -32768); end
      3'd1: begin sr = sa - sb_; e.res = 16'(sr); e.ovf = (sr > 32767) || (sr < -32768); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = 16'(int'(a) * (2 ** int'(b[3:0])));
      3'd6: e.res = 16'(int'(a) / (2 ** int'(b[3:0])));
      default: begin p = longint'(a) * longint'(b); e.res = p[15:0]; end
    endcase
    e.zero = (e.res == 16'h0);
    e.st   = pick(i.ss, i.sd, i);
    e.opc  = i.opc;
    e.dest = i.dest;
    e.mwe  = i.mwe;
    e.wbm  = i.wbm;
    e.wbe  = i.wbe;
    return e;
  endfunction

  function automatic ins_t mk(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b);
    ins_t i;
    i.valid = 1'b1; i.flush = 1'b0; i.cmd = cmd;
    i.opc = 4'($urandom); i.s1 = 2'b00; i.s2 = 2'b00; i.ss = 2'b00;
    i.ex = 16'($urandom); i.mem = 16'($urandom); i.wb = 16'($urandom);
    i.r1 = a; i.r2 = b; i.sd = 16'($urandom);
    i.dest = 3'($urandom); i.mwe = 1'($urandom); i.wbm = 1'($urandom); i.wbe = 1'($urandom);
    return i;
  endfunction

  task automatic drive(input ins_t i);
    bus.flush = i.flush; bus.id_ex_valid = i.valid; bus.id_ex_cmd = i.cmd;
    bus.id_ex_opcode = i.opc; bus.frwd_op1_sel = i.s1; bus.frwd_op2_sel = i.s2;
    bus.frwd_store_sel = i.ss; bus.frwd_res_ex = i.ex; bus.frwd_res_mem = i.mem;
    bus.frwd_res_wb = i.wb; bus.rs_1 = i.r1; bus.rs_2 = i.r2; bus.id_ex_store_data = i.sd;
    bus.id_ex_op_dest = i.dest; bus.id_ex_mem_write_en = i.mwe;
    bus.id_ex_wb_mux = i.wbm; bus.id_ex_wb_en = i.wbe;
  endtask

  // Called just after a rising edge; returns just after the edge that consumed the instruction.
  task automatic issue(input ins_t i);
    int hi;
    logic s;
    bit mul_acc, done;
    drive(i);
    mul_acc = i.valid && !i.flush && (i.cmd == 3'd7);
    if (i.valid && !i.flush) sb.push_back(model(i));
    hi = 0;
    done = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      s = bus.stall;
      if (s) hi++;
      if (mul_acc && n > 0) chk("mul_busy_bubble", 64'(bus.ex_valid), 64'd0);
      @(posedge clk);
      #1;
      if (!s) begin done = 1'b1; break; end
      // Forwarded sources are free to move while the multiply is in flight.
      bus.frwd_res_ex = 16'($urandom); bus.frwd_res_mem = 16'($urandom);
      bus.frwd_res_wb = 16'($urandom); bus.rs_1 = 16'($urandom);
      bus.rs_2 = 16'($urandom); bus.id_ex_store_data = 16'($urandom);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stall_timeout: stall still high after 64 cycles");
    end
    if (mul_acc) begin
      chk("mul_stall_cycles", 64'(hi), 64'(DW));
      chk("mul_result_valid", 64'(bus.ex_valid), 64'd1);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_outputs"}, 64'({bus.ex_valid, bus.opcode_ex_mem, bus.alu_res, bus.ex_store_data,
                                 bus.ex_zero, bus.ex_ovf, bus.ex_op_dest, bus.ex_mem_write_en,
                                 bus.ex_wb_mux, bus.ex_wb_en}), 64'd0);
    chk({name, "_stall"}, 64'(bus.stall), 64'd0);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    @(negedge clk);
    wait (!rst);
    forever begin
      @(negedge clk);
      if (bus.ex_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: result 0x%0h with empty scoreboard at %0t", bus.alu_res, $time);
        end else begin
          e = sb.pop_front();
          chk("alu_res", 64'(bus.alu_res), 64'(e.res));
          chk("store_data", 64'(bus.ex_store_data), 64'(e.st));
          chk("zero_ovf", 64'({bus.ex_zero, bus.ex_ovf}), 64'({e.zero, e.ovf}));
          chk("sideband", 64'({bus.opcode_ex_mem, bus.ex_op_dest, bus.ex_mem_write_en,
                               bus.ex_wb_mux, bus.ex_wb_en}),
                          64'({e.opc, e.dest, e.mwe, e.wbm, e.wbe}));
        end
      end else begin
        chk("bubble_en", 64'({bus.ex_wb_en, bus.ex_mem_write_en}), 64'd0);
      end
    end
  end

  initial begin : stim
    ins_t i, idle;
    idle = mk(3'd0, 16'h0, 16'h0);
    idle.valid = 1'b0;

    // Reset, with a MUL presented to show stall stays low under reset.
    i = mk(3'd7, 16'h3, 16'h5);
    drive(i);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);

    // Overflowing ADD then SUB wrapping to 0xFFFF.
    issue(mk(3'd0, 16'h7FFF, 16'h0001));
    chk("add_ovf_res", 64'({bus.alu_res, bus.ex_ovf}), 64'({16'h8000, 1'b1}));
    issue(mk(3'd1, 16'h0000, 16'h0001));
    chk("sub_res", 64'({bus.alu_res, bus.ex_ovf, bus.ex_zero}), 64'({16'hFFFF, 1'b0, 1'b0}));

    // Forwarded SHL and store data.
    i = mk(3'd5, 16'h0001, 16'h0000);
    i.s1 = 2'b11; i.mem = 16'h0010;
    i.s2 = 2'b01; i.wb = 16'h0003;
    i.ss = 2'b10; i.ex = 16'hBEEF;
    issue(i);
    chk("fwd_shl", 64'(bus.alu_res), 64'h0080);
    chk("fwd_store", 64'(bus.ex_store_data), 64'hBEEF);

    // MUL with an AND queued behind it.
    i = mk(3'd7, 16'h0000, 16'h0045);
    i.s1 = 2'b10; i.ex = 16'h0123;
    issue(i);
    chk("mul_res", 64'(bus.alu_res), 64'h4E6F);
    issue(mk(3'd2, 16'h00F0, 16'h0FF0));
    chk("and_after_mul", 64'(bus.alu_res), 64'h00F0);

    issue(mk(3'd7, 16'hFFFF, 16'hFFFF));
    chk("mul_ffff", 64'(bus.alu_res), 64'h0001);
    issue(mk(3'd7, 16'h1234, 16'h0000));
    chk("mul_zero", 64'({bus.alu_res, bus.ex_zero}), 64'({16'h0000, 1'b1}));

    // Flush in BUSY at cnt=5.
    drive(mk(3'd7, 16'h0101, 16'h0202));
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    i = idle; i.flush = 1'b1;
    drive(i);
    @(negedge clk);
    chk("flush_busy_stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
    drive(idle);
    @(negedge clk);
    chk("flush_busy_after", 64'({bus.busy, bus.stall, bus.ex_valid}), 64'd0);
    @(posedge clk);
    #1;
    repeat (20) issue(idle);

    // Flush in IDLE with a live instruction.
    i = mk(3'd3, 16'h00AA, 16'h5500);
    i.flush = 1'b1; i.wbe = 1'b1; i.mwe = 1'b1;
    issue(i);
    chk("flush_idle", 64'({bus.ex_valid, bus.ex_wb_en}), 64'd0);

    // Reset mid-MUL.
    drive(mk(3'd7, 16'h0033, 16'h0044));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mul_stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    @(negedge clk);
    check_zero("rst_mid_mul");
    @(posedge clk);
    #1;
    repeat (20) issue(idle);

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) issue(mk(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom)));
    drive(mk(3'd0, 16'h1111, 16'h2222));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    @(negedge clk);
    check_zero("rst_stream");
    @(posedge clk);
    #1;
    issue(mk(3'd0, 16'h0002, 16'h0002));
    chk("add_after_rst", 64'(bus.alu_res), 64'h0004);

    // Random stream.
    for (int k = 0; k < 300; k++) begin
      i = mk(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      i.s1 = 2'($urandom); i.s2 = 2'($urandom); i.ss = 2'($urandom);
      i.valid = ($urandom_range(0, 9) != 0);
      i.flush = ($urandom_range(0, 19) == 0);
      issue(i);
    end
    repeat (3) issue(idle);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never appeared", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised multi-cycle execute stage sitting between the ID/EX and EX/MEM pipeline registers. It resolves the operand and store-data forwarding, runs single-cycle ALU operations and an iterative shift-add multiply, and registers the result and sideband into EX/MEM. It also drives a stall back to ID while a multiply is in flight and honours a pipeline flush.

## Interface
Parameters:
- DATA_W, 16: datapath width; must be ≥ 4.
- RA_W, 3: destination register address width.
- OPC_W, 4: opcode width carried to MEM.

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the instruction in EX
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_opcode  in  OPC_W  opcode, passed through
- id_ex_cmd  in  3  ALU command
- frwd_op1_sel, frwd_op2_sel, frwd_store_sel  in  2 each  forwarding selects
- frwd_res_ex, frwd_res_mem, frwd_res_wb  in  DATA_W  forwarded results
- rs_1, rs_2, id_ex_store_data  in  DATA_W  register-file operands and store data
- id_ex_op_dest  in  RA_W  destination register
- id_ex_mem_write_en, id_ex_wb_mux, id_ex_wb_en  in  1 each  control sideband
- stall  out  1  ID/EX must hold (combinational)
- busy  out  1  multiply FSM not IDLE
- ex_valid  out  1  EX/MEM holds a real instruction
- opcode_ex_mem  out  OPC_W  registered opcode
- alu_res, ex_store_data  out  DATA_W  registered result and store data
- ex_zero, ex_ovf  out  1 each  result == 0; signed overflow (ADD/SUB only)
- ex_op_dest  out  RA_W  registered destination
- ex_mem_write_en, ex_wb_mux, ex_wb_en  out  1 each  registered sideband

## Operation
- Forwarding select encoding, applied to op1, op2 and store data independently:
  - 2'b10 selects EX.
  - 2'b11 selects MEM.
  - 2'b01 selects WB.
  - 2'b00 selects the register-file value.
- Commands:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL and 6 SHR (logical). Shift amount is op2 low $clog2(DATA_W) bits.
  - 7 MUL: low DATA_W bits of the unsigned product.
- Arithmetic is modulo 2^DATA_W. ex_ovf is the signed overflow of ADD/SUB; it is 0 for every other command.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - An instruction is accepted when id_ex_valid=1 and flush=0.
  - Non-MUL: the result, the forwarded store data and the sideband are registered at the edge. ex_valid=1.
  - MUL: the forwarded op1/op2, forwarded store data, opcode and sideband are captured at the edge. The FSM moves to BUSY with cnt=0, and a bubble is written.
- BUSY:
  - Each edge performs one shift-add iteration and increments cnt.
  - The edge at which cnt==DATA_W-1 does the final iteration and registers the product with the captured sideband. ex_valid=1 and the FSM returns to IDLE.
  - In every other BUSY cycle a bubble is written.
  - The ID/EX inputs are ignored in BUSY; forwarded values may change there without effect.
- A bubble writes ex_valid=0, ex_wb_en=0 and ex_mem_write_en=0. The other EX/MEM fields are don't-care but are driven to 0.
- stall = (IDLE & id_ex_valid & cmd==MUL & ~flush) | (BUSY & cnt!=DATA_W-1). ID/EX advances at the edge where the final product is written.
- busy = (state==BUSY).
- flush:
  - In IDLE, the inputs are discarded and a bubble is written.
  - In BUSY, the multiply is aborted, the FSM returns to IDLE, cnt is cleared and a bubble is written.
  - stall is 0 in any cycle where flush=1.
- rst has priority over flush; flush has priority over everything else.
- Reset values: all outputs 0, state IDLE, cnt 0, internal operand registers 0. stall=0 during reset.

## Timing
- Non-MUL latency: 1 cycle. The result is visible in the cycle after acceptance.
- MUL accepted in cycle T:
  - stall is high in cycles T through T+DATA_W-1 (DATA_W cycles).
  - Result is visible in cycle T+DATA_W+1, with ex_valid=1 for exactly one cycle.
- Back-to-back non-MUL instructions sustain 1 per cycle.
- A MUL followed by any instruction: the next instruction is accepted in cycle T+DATA_W+1.
- rst asserted mid-multiply: the next cycle shows IDLE, stall=0 and all outputs 0, with no result ever emitted.

## Test plan
- DATA_W=16, back-to-back ADD 0x7FFF+0x0001 then SUB 0x0000-0x0001: alu_res 0x8000 with ex_ovf=1 in cycle 2; 0xFFFF with ex_ovf=0 and ex_zero=0 in cycle 3.
- Forwarding: rs_1=1, frwd_op1_sel=2'b11 with frwd_res_mem=0x0010, op2 sel 2'b01 with WB=0x0003, cmd SHL → 0x0080. Store sel 2'b10 with EX=0xBEEF → ex_store_data=0xBEEF.
- MUL 0x0123*0x0045 accepted at T, op1 forward source toggled during BUSY:
  - stall high exactly 16 cycles.
  - alu_res=0x4E6F with ex_valid=1 only in cycle T+17.
  - The AND presented behind it (0x00F0&0x0FF0) is accepted in cycle T+17 and yields 0x00F0 in T+18.
- MUL 0xFFFF*0xFFFF → 0x0001. MUL by 0 → 0x0000 with ex_zero=1.
- flush asserted in BUSY cycle cnt=5:
  - Bubble written, busy=0 and stall=0 next cycle, no MUL result emitted.
  - flush with id_ex_valid=1 in IDLE → ex_valid=0 and ex_wb_en=0.
- rst asserted mid-MUL and mid-stream: every output 0 and stall=0 the cycle after. A fresh ADD 2+2 afterwards yields 0x0004 one cycle later.
